// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS main control unit.
//   - opcode constants for the supported instruction classes
//   - state encodings of the main control FSM
//   - ALUOp codes passed to the ALU control unit
//   - packed control vector produced by the output decoder
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EXEC = 4'd10,
        ADDI_WB   = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_SUB  = 2'b01,
        ALU_FUNC = 2'b10
    } aluop_t;

    // One bit (or field) per datapath control; the decoder clears the whole
    // vector first so anything a state does not mention reads as 0.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic [1:0] pc_source;
        aluop_t     alu_op;
        logic [1:0] alu_src_b;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
    } ctrl_t;

    // lw and sw share the address-calculation step.
    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/multicycle_main_control_if.sv
// Bundle between the main control unit and the datapath.
//   master : control unit side (reads opcode/mem_ready, drives controls)
//   slave  : datapath side (drives opcode/mem_ready, reads controls)
// Signals: opcode (IR[31:26]), mem_ready, all datapath control strobes and
// selects, plus debug state, retired-instruction count and illegal flag.
interface multicycle_main_control_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             PCWrite;
    logic             PCWriteCond;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             MemtoReg;
    logic             IRWrite;
    logic [1:0]       PCSource;
    logic             ALUOp1;
    logic             ALUOp0;
    logic [1:0]       ALUSrcB;
    logic             ALUSrcA;
    logic             RegWrite;
    logic             RegDst;
    logic [3:0]       state;
    logic [CNT_W-1:0] instr_count;
    logic             illegal_op;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
               IRWrite, PCSource, ALUOp1, ALUOp0, ALUSrcB, ALUSrcA,
               RegWrite, RegDst, state, instr_count, illegal_op
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
               IRWrite, PCSource, ALUOp1, ALUOp0, ALUSrcB, ALUSrcA,
               RegWrite, RegDst, state, instr_count, illegal_op
    );
endinterface

// File: rtl/mc_output_decode.sv
// Combinational output decoder for the main control FSM.
//   state     : current FSM state
//   mem_ready : memory handshake; only gates IR/PC load in FETCH
//   ctrl      : full datapath control vector
module mc_output_decode
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = 2'b01;
                ctrl.alu_op    = ALU_ADD;
                // PC+4 and the IR load only commit once the fetch completes.
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            DECODE: begin
                // Speculative branch target: PC + (signext << 2).
                ctrl.alu_src_b = 2'b11;
                ctrl.alu_op    = ALU_ADD;
            end
            MEM_ADDR, ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                ctrl.alu_op    = ALU_ADD;
            end
            MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            MEM_WRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_FUNC;
            end
            R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = 2'b01;
            end
            JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = 2'b10;
            end
            ADDI_WB: begin
                ctrl.reg_write = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multi-cycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback for R-type, lw, sw, beq,
// j and addi, stalling on the memory ready handshake.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : master side of multicycle_main_control_if (opcode/mem_ready in,
//           datapath controls, debug state, instr_count, illegal_op out)
module multicycle_main_control
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    multicycle_main_control_if.master   bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_reg;
    logic [CNT_W-1:0] count_reg;
    logic             illegal_reg;
    ctrl_t            ctrl;

    // The count is bumped on the same edge that retires an instruction back
    // to FETCH; illegal opcodes return to FETCH without retiring.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= FETCH;
            count_reg   <= '0;
            illegal_reg <= 1'b0;
        end else begin
            case (state_reg)
                FETCH: begin
                    if (bus.mem_ready) state_reg <= DECODE;
                end
                DECODE: begin
                    if (is_mem_op(bus.opcode)) begin
                        state_reg <= MEM_ADDR;
                    end else if (bus.opcode == OP_RTYPE) begin
                        state_reg <= EXECUTE;
                    end else if (bus.opcode == OP_BEQ) begin
                        state_reg <= BRANCH;
                    end else if (bus.opcode == OP_J) begin
                        state_reg <= JUMP;
                    end else if (bus.opcode == OP_ADDI) begin
                        state_reg <= ADDI_EXEC;
                    end else begin
                        state_reg   <= FETCH;
                        illegal_reg <= 1'b1;
                    end
                end
                MEM_ADDR: begin
                    state_reg <= (bus.opcode == OP_SW) ? MEM_WRITE : MEM_READ;
                end
                MEM_READ: begin
                    if (bus.mem_ready) state_reg <= MEM_WB;
                end
                MEM_WRITE: begin
                    if (bus.mem_ready) begin
                        state_reg <= FETCH;
                        count_reg <= count_reg + CNT_ONE;
                    end
                end
                EXECUTE:   state_reg <= R_WB;
                ADDI_EXEC: state_reg <= ADDI_WB;
                MEM_WB, R_WB, BRANCH, JUMP, ADDI_WB: begin
                    state_reg <= FETCH;
                    count_reg <= count_reg + CNT_ONE;
                end
                default: state_reg <= FETCH;
            endcase
        end
    end

    mc_output_decode u_decode (
        .state     (state_reg),
        .mem_ready (bus.mem_ready),
        .ctrl      (ctrl)
    );

    assign bus.PCWrite     = ctrl.pc_write;
    assign bus.PCWriteCond = ctrl.pc_write_cond;
    assign bus.IorD        = ctrl.iord;
    assign bus.MemRead     = ctrl.mem_read;
    assign bus.MemWrite    = ctrl.mem_write;
    assign bus.MemtoReg    = ctrl.mem_to_reg;
    assign bus.IRWrite     = ctrl.ir_write;
    assign bus.PCSource    = ctrl.pc_source;
    assign bus.ALUOp1      = ctrl.alu_op[1];
    assign bus.ALUOp0      = ctrl.alu_op[0];
    assign bus.ALUSrcB     = ctrl.alu_src_b;
    assign bus.ALUSrcA     = ctrl.alu_src_a;
    assign bus.RegWrite    = ctrl.reg_write;
    assign bus.RegDst      = ctrl.reg_dst;
    assign bus.state       = state_reg;
    assign bus.instr_count = count_reg;
    assign bus.illegal_op  = illegal_reg;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Randomized self-checking bench for multicycle_main_control. Each
// instruction is planned as a list of (state, mem_ready) cycles derived from
// the instruction class and chosen stall counts; every cycle the outputs are
// compared with a per-state table of expected controls.
module tb_multicycle_main_control;
    localparam int CNT_W = 4;   // small so the counter wrap is exercised

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_main_control_if #(.CNT_W(CNT_W)) bus();

    multicycle_main_control #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_pass   = 0;
    int n_checks = 0;
    int exp_count = 0;
    bit exp_illegal = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Expected control vector, packed as
    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,PCSource,
    //  ALUOp1,ALUOp0,ALUSrcB,ALUSrcA,RegWrite,RegDst}
    function automatic logic [16:0] exp_ctrl(input int st, input bit rdy);
        logic pcw = 0, pcwc = 0, iord = 0, mr = 0, mw = 0, m2r = 0, irw = 0;
        logic [1:0] pcs = 0, aop = 0, srcb = 0;
        logic srca = 0, rw = 0, rd = 0;
        case (st)
            0:  begin mr = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
            1:  begin srcb = 2'b11; end
            2, 10: begin srca = 1; srcb = 2'b10; end
            3:  begin mr = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; iord = 1; end
            6:  begin srca = 1; aop = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            9:  begin pcw = 1; pcs = 2'b10; end
            11: begin rw = 1; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mr, mw, m2r, irw, pcs, aop, srcb, srca, rw, rd};
    endfunction

    function automatic logic [16:0] dut_ctrl();
        return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                bus.MemtoReg, bus.IRWrite, bus.PCSource, bus.ALUOp1, bus.ALUOp0,
                bus.ALUSrcB, bus.ALUSrcA, bus.RegWrite, bus.RegDst};
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
               op == 6'b000100 || op == 6'b000010 || op == 6'b001000;
    endfunction

    task automatic check_now(input int st, input bit rdy);
        chk($sformatf("state/st%0d", st), 32'(bus.state), 32'(st));
        chk($sformatf("ctrl/st%0d", st), 32'(dut_ctrl()), 32'(exp_ctrl(st, rdy)));
        chk($sformatf("count/st%0d", st), 32'(bus.instr_count), 32'(exp_count));
        chk($sformatf("illegal/st%0d", st), 32'(bus.illegal_op), 32'(exp_illegal));
    endtask

    // One clock of the plan: drive inputs mid-cycle, then check outputs.
    task automatic step(input int st, input bit rdy, input logic [5:0] op);
        @(negedge clk);
        bus.mem_ready = rdy;
        bus.opcode    = op;
        #1;
        check_now(st, rdy);
    endtask

    // Whole instruction: fs fetch stalls, ms memory stalls.
    task automatic run_instr(input logic [5:0] op, input int fs, input int ms);
        int cycles = 0;
        for (int i = 0; i < fs; i++) begin step(0, 1'b0, 6'($urandom)); cycles++; end
        step(0, 1'b1, 6'($urandom)); cycles++;
        step(1, 1'($urandom), op); cycles++;
        case (op)
            6'b100011: begin
                step(2, 1'($urandom), op);
                for (int i = 0; i < ms; i++) step(3, 1'b0, op);
                step(3, 1'b1, op);
                step(4, 1'($urandom), op);
                cycles += 3 + ms;
            end
            6'b101011: begin
                step(2, 1'($urandom), op);
                for (int i = 0; i < ms; i++) step(5, 1'b0, op);
                step(5, 1'b1, op);
                cycles += 2 + ms;
            end
            6'b000000: begin step(6, 1'($urandom), op); step(7, 1'($urandom), op); cycles += 2; end
            6'b001000: begin step(10, 1'($urandom), op); step(11, 1'($urandom), op); cycles += 2; end
            6'b000100: begin step(8, 1'($urandom), op); cycles += 1; end
            6'b000010: begin step(9, 1'($urandom), op); cycles += 1; end
            default: ;
        endcase
        if (is_legal(op)) exp_count = (exp_count + 1) % (1 << CNT_W);
        else exp_illegal = 1'b1;
        $display("instr op=%b fstall=%0d mstall=%0d cycles=%0d count=%0d illegal=%0d",
                 op, fs, ms, cycles, exp_count, exp_illegal);
    endtask

    initial begin
        logic [5:0] ops [6];
        logic [5:0] op;
        ops[0] = 6'b100011; ops[1] = 6'b101011; ops[2] = 6'b000000;
        ops[3] = 6'b000100; ops[4] = 6'b000010; ops[5] = 6'b001000;

        rst_n = 1'b0;
        bus.mem_ready = 1'b0;
        bus.opcode = 6'd0;
        repeat (2) @(negedge clk);
        #1;
        check_now(0, 1'b0);
        rst_n = 1'b1;

        // Directed: lw, R-type, sw with 3 write stalls, beq, j, illegal.
        run_instr(6'b100011, 0, 0);
        run_instr(6'b000000, 0, 0);
        run_instr(6'b101011, 0, 3);
        run_instr(6'b000100, 0, 0);
        run_instr(6'b000010, 0, 0);
        run_instr(6'b111111, 0, 0);

        // Random mix, long enough to wrap the 4-bit counter.
        for (int n = 0; n < 40; n++) begin
            int k = $urandom_range(0, 6);
            if (k == 6) begin
                do op = 6'($urandom_range(0, 63)); while (is_legal(op));
            end else begin
                op = ops[k];
            end
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 2));
        end

        // Illegal opcode, then reset in the middle of a stalled lw.
        run_instr(6'b111111, 1, 0);
        step(0, 1'b1, 6'($urandom));
        step(1, 1'b1, 6'b100011);
        step(2, 1'b1, 6'b100011);
        step(3, 1'b0, 6'b100011);
        @(negedge clk);
        rst_n = 1'b0;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        #1;
        exp_count = 0;
        exp_illegal = 1'b0;
        check_now(0, 1'b0);
        rst_n = 1'b1;
        $display("reset during MEM_READ: count=%0d illegal=%0d", exp_count, exp_illegal);
        run_instr(6'b100011, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
